// File: rtl/aes_usb_pkg.sv
// -----------------------------------------------------------------------------
// aes_usb_pkg
// Shared definitions for the USB-receive to AES block scheduler:
//   state_t             scheduler FSM states
//   BLOCK_BYTES         bytes per AES block (128-bit datapath)
//   PAD_BYTE            fill value for the tail of a short final block
//   AES_TIMEOUT_DEFAULT default cycle limit from aes_start to aes_done
// -----------------------------------------------------------------------------
package aes_usb_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam logic [7:0] PAD_BYTE = 8'h00;
  localparam int AES_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    START,
    WAIT_AES,
    UNLOAD,
    DRAIN
  } state_t;

endpackage

// File: rtl/aes_block_buf.sv
// -----------------------------------------------------------------------------
// aes_block_buf
// 16 x 8-bit block buffer shared by plaintext assembly and ciphertext unload.
// Byte 0 is the most significant byte of the 128-bit view ([127:120]).
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset (clears all bytes)
//   wr_en/wr_idx/wr_data   single byte write
//   ld_en/ld_data     128-bit parallel load (ciphertext capture)
//   pad_en/pad_idx    write PAD_BYTE to every byte at index >= pad_idx
//   rd_idx/rd_data    byte read
//   pt                128-bit parallel read
// Simultaneous operations resolve as load > pad > byte write.
// -----------------------------------------------------------------------------
module aes_block_buf
  import aes_usb_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [7:0]   wr_data,
  input  logic         ld_en,
  input  logic [127:0] ld_data,
  input  logic         pad_en,
  input  logic [3:0]   pad_idx,
  input  logic [3:0]   rd_idx,
  output logic [127:0] pt,
  output logic [7:0]   rd_data
);

  logic [7:0] mem [BLOCK_BYTES];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < BLOCK_BYTES; i++) mem[i] <= '0;
    end else if (ld_en) begin
      for (int i = 0; i < BLOCK_BYTES; i++) mem[i] <= ld_data[127-8*i -: 8];
    end else if (pad_en) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (i >= int'(pad_idx)) mem[i] <= PAD_BYTE;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    pt = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) pt[127-8*i -: 8] = mem[i];
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/aes_block_sched.sv
// -----------------------------------------------------------------------------
// aes_block_sched
// Drains received bytes from the RX FIFO into a 16-byte block, starts the AES
// core, waits for the ciphertext and streams it byte-wise into the TX FIFO.
// A short final block (end of packet) is zero padded; a partial block hit by a
// receive error is discarded and the rest of the packet drained.
// Ports:
//   clk, n_rst             clock, asynchronous active-low reset
//   rx_empty, rx_rdata     RX FIFO status / first-word-fall-through head
//   rx_read                pop RX head this cycle
//   rcving, r_error        receiver busy / receiver error
//   aes_start, aes_pt      one-cycle start pulse, plaintext block
//   aes_done, aes_ct       one-cycle completion pulse, ciphertext
//   tx_full                TX FIFO full
//   tx_write, tx_wdata     push a ciphertext byte, MSB byte first
//   clr_err                clear err_flag
//   busy, err_flag, blk_cnt  status: not idle, sticky error, blocks sent
//   dbg_state              current FSM state
//
// Handshakes: a byte moves on the RX side in every cycle where rx_read=1
// (rx_read is only raised while rx_empty=0), and on the TX side in every cycle
// where tx_write=1 (tx_write is only raised while tx_full=0). Both strobes are
// combinational from the current state and the FIFO flag, so a byte per cycle
// flows in each direction.
// -----------------------------------------------------------------------------
module aes_block_sched
  import aes_usb_pkg::*;
#(
  parameter int BLOCK_BYTES = aes_usb_pkg::BLOCK_BYTES,
  parameter int AES_TIMEOUT = AES_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             rx_empty,
  input  logic [7:0]       rx_rdata,
  output logic             rx_read,
  input  logic             rcving,
  input  logic             r_error,
  output logic             aes_start,
  output logic [127:0]     aes_pt,
  input  logic             aes_done,
  input  logic [127:0]     aes_ct,
  input  logic             tx_full,
  output logic             tx_write,
  output logic [7:0]       tx_wdata,
  input  logic             clr_err,
  output logic             busy,
  output logic             err_flag,
  output logic [CNT_W-1:0] blk_cnt,
  output state_t           dbg_state
);

  localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);
  localparam int TMR_W = $clog2(AES_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(AES_TIMEOUT - 1);

  state_t           state;
  logic [3:0]       count;
  logic [TMR_W-1:0] timer;
  logic             rcving_q;
  logic             pkt_end;

  logic             load_pop;
  logic             timeout;
  logic             pkt_fall;
  logic             pkt_clr;
  logic             err_set;
  logic [7:0]       buf_byte;

  // A pop in LOAD is suppressed while r_error is high so an erroring packet
  // never contributes a byte to the block.
  assign load_pop  = (state == LOAD) && !rx_empty && !r_error;
  assign rx_read   = load_pop || ((state == DRAIN) && !rx_empty);
  assign tx_write  = (state == UNLOAD) && !tx_full;
  assign tx_wdata  = (state == UNLOAD) ? buf_byte : 8'h00;
  assign aes_start = (state == START);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Timer runs from 0 in START; aes_done is still honoured on the last cycle.
  assign timeout  = (state == WAIT_AES) && (timer == TO_LAST);
  assign pkt_fall = rcving_q && !rcving;

  // pkt_end is consumed when LOAD leaves on an empty FIFO (to PAD or IDLE),
  // when no block is open and the FIFO is empty, or when a drain completes.
  assign pkt_clr = ((state == LOAD) && !r_error && rx_empty && pkt_end)
                 || (((state == LOAD) || (state == IDLE)) && (count == 4'd0) && rx_empty)
                 || ((state == DRAIN) && rx_empty && !r_error);

  assign err_set = ((state == LOAD) && r_error && (count != 4'd0))
                 || (timeout && !aes_done);

  aes_block_buf u_buf (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (load_pop),
    .wr_idx  (count),
    .wr_data (rx_rdata),
    .ld_en   ((state == WAIT_AES) && aes_done),
    .ld_data (aes_ct),
    .pad_en  (state == PAD),
    .pad_idx (count),
    .rd_idx  (count),
    .pt      (aes_pt),
    .rd_data (buf_byte)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      count    <= '0;
      timer    <= '0;
      rcving_q <= 1'b0;
      pkt_end  <= 1'b0;
      err_flag <= 1'b0;
      blk_cnt  <= '0;
    end else begin
      rcving_q <= rcving;

      // A new end-of-packet edge must not be lost to a same-cycle clear.
      if (pkt_fall)     pkt_end <= 1'b1;
      else if (pkt_clr) pkt_end <= 1'b0;

      if (err_set)      err_flag <= 1'b1;
      else if (clr_err) err_flag <= 1'b0;

      if ((state == START) || (state == WAIT_AES)) timer <= timer + TMR_W'(1);
      else                                          timer <= '0;

      case (state)
        IDLE: begin
          count <= '0;
          if (r_error)        state <= DRAIN;
          else if (!rx_empty) state <= LOAD;
        end

        LOAD: begin
          if (r_error) begin
            count <= '0;
            state <= DRAIN;
          end else if (!rx_empty) begin
            count <= count + 4'd1;
            if (count == LAST_IDX) state <= START;
          end else if (pkt_end) begin
            state <= (count != 4'd0) ? PAD : IDLE;
          end
        end

        PAD: begin
          count <= '0;
          state <= START;
        end

        START: state <= WAIT_AES;

        WAIT_AES: begin
          if (aes_done) begin
            count <= '0;
            state <= UNLOAD;
          end else if (timeout) begin
            state <= IDLE;
          end
        end

        UNLOAD: begin
          if (!tx_full) begin
            count <= count + 4'd1;
            if (count == LAST_IDX) begin
              blk_cnt <= blk_cnt + CNT_W'(1);
              count   <= '0;
              state   <= rx_empty ? IDLE : LOAD;
            end
          end
        end

        DRAIN: begin
          count <= '0;
          if (rx_empty && !r_error) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_block_sched.md
Name: aes_block_sched

Overview:
Scheduler between the USB receive path and the AES core.
- Drains received bytes from the RX FIFO, which is written by the receiver controller's w_enable.
- Assembles each 128-bit plaintext block, starts the AES core, waits for completion, then streams the 16 ciphertext bytes into the TX FIFO.
- Zero-pads the final partial block at end of packet.
- Discards partial blocks on receive errors.

Parameters:
BLOCK_BYTES, 16, bytes per AES block (fixed 128-bit datapath; other values unsupported)
AES_TIMEOUT, 64, max cycles from aes_start to aes_done before timeout error
CNT_W, 16, width of the completed-block counter

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
rx_empty  in  1  RX FIFO empty
rx_rdata  in  8  RX FIFO head byte (first-word-fall-through, valid when !rx_empty)
rx_read  out  1  pop RX FIFO head this cycle
rcving  in  1  receiver controller busy with a packet
r_error  in  1  receiver error flag
aes_start  out  1  one-cycle start pulse to AES core
aes_pt  out  128  plaintext block; first received byte at [127:120]
aes_done  in  1  one-cycle completion pulse from AES core
aes_ct  in  128  ciphertext, valid in the aes_done cycle
tx_full  in  1  TX FIFO full
tx_write  out  1  push tx_wdata into TX FIFO
tx_wdata  out  8  ciphertext byte; aes_ct[127:120] first
clr_err  in  1  clears err_flag
busy  out  1  high in every state except IDLE
err_flag  out  1  sticky error: timeout or discarded block
blk_cnt  out  CNT_W  blocks sent to TX, wraps at 2^CNT_W

Behaviour:
- Reset: all outputs 0, state IDLE, byte count 0, pkt_end latch 0, rcving_q 0.
- pkt_end logic:
  - rcving_q is the registered rcving.
  - pkt_end sets on a falling edge of rcving (rcving_q=1 and rcving=0).
  - pkt_end clears on entry to PAD, or in LOAD/IDLE when count==0 and rx_empty.
- IDLE:
  - !rx_empty -> LOAD. No pop occurs in the transition cycle.
  - r_error=1 -> DRAIN.
- LOAD:
  - rx_read = !rx_empty && !r_error.
  - Each pop shifts rx_rdata into the block buffer at the byte selected by count; count increments.
  - Pop of the 16th byte (count==15) -> START.
  - rx_empty && pkt_end && count>0 -> PAD.
  - rx_empty && pkt_end && count==0 -> IDLE.
  - r_error=1 -> DRAIN, count=0, err_flag=1 if count>0. r_error beats a simultaneous byte: no pop in that cycle.
- PAD: fills the remaining bytes with 0x00 in a single cycle, then -> START.
- START: aes_start=1 for exactly one cycle, aes_pt stable from here until aes_done; timer=0; then -> WAIT_AES.
- WAIT_AES:
  - aes_done=1 captures aes_ct into the buffer -> UNLOAD, count=0.
  - timer reaching AES_TIMEOUT-1 without aes_done -> IDLE, err_flag=1, block dropped.
  - aes_done in the same cycle as timeout: done wins.
- UNLOAD:
  - tx_write = !tx_full; tx_wdata = buffer byte[count], MSB byte first.
  - Writes are combinational with tx_full: tx_full=1 stalls with no write and no count change.
  - Write of the 16th byte -> blk_cnt+1, count=0, then -> LOAD if !rx_empty, else IDLE.
  - r_error is ignored in UNLOAD; it is sampled again only in IDLE/LOAD.
- DRAIN:
  - rx_read = !rx_empty, discarding bytes.
  - rx_empty && !r_error -> IDLE; pkt_end cleared.
- err_flag: set by the events above; cleared by clr_err. A set event in the same cycle as clr_err wins.
- Throughput: 1 byte/cycle in and out. Minimum block latency from first pop to last tx_write = 16 + 1 + AES latency + 16 cycles.
- Reset mid-operation: in-flight block discarded, no partial TX writes continue.

Decomposition:
- Package aes_usb_pkg holds:
  - state typedef {IDLE, LOAD, PAD, START, WAIT_AES, UNLOAD, DRAIN}
  - BLOCK_BYTES
  - PAD_BYTE=8'h00
  - AES_TIMEOUT default
- Sub-module aes_block_buf: 16x8 register file with byte write at an index, a 128-bit parallel load (ct), a pad-fill-from-index operation, 128-bit parallel read (pt) and byte read at an index.
- The FSM, counters and timer live in aes_block_sched.

Test Plan:
- 16 bytes 0x00..0x0F into RX FIFO, AES model returns pt XOR all-0xFF after 10 cycles -> aes_pt=0x000102...0F, one aes_start pulse, tx bytes 0xFF,0xFE..0xF0 in order, blk_cnt=1.
- 5 bytes 0xA1..0xA5 then rcving 1->0 -> aes_pt=0xA1A2A3A4A5 followed by 11 zero bytes, 16 tx writes.
- r_error asserted after 7 of 16 bytes, 3 bytes remaining in FIFO -> no aes_start, those 3 bytes popped in DRAIN, err_flag=1; clr_err -> err_flag=0.
- AES model never pulses aes_done -> return to IDLE exactly AES_TIMEOUT cycles after aes_start, err_flag=1, no tx_write.
- tx_full asserted for 4 cycles mid-UNLOAD (after byte 6) -> no writes while full, byte 7 written first cycle tx_full=0, all 16 bytes in order.
- 32 back-to-back bytes -> two blocks, blk_cnt=2. Reset asserted during the second WAIT_AES -> all outputs 0, blk_cnt=0.
